// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain controller.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read port plus valid/ready output stream seen by the drain controller.
interface fifo_drain_ctrl_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W
);
    logic              rd_sig;
    logic              empty_sig;
    logic              under_flow;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    // Controller side: issues reads, sources the stream.
    modport master (
        output rd_sig,
        input  empty_sig,
        input  under_flow,
        input  din,
        output dout,
        output dout_valid,
        input  dout_ready
    );

    // FIFO / consumer side.
    modport slave (
        input  rd_sig,
        output empty_sig,
        output under_flow,
        output din,
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/fifo_drain_ctrl_skid_buf2.sv
// Two-entry in-order buffer; slot 0 is always the head presented downstream.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] slot_reg  [2];
    logic [DATA_W-1:0] slot_next [2];
    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic [1:0]        occ_after_pop;
    logic              pop_ok;
    logic              push_ok;

    // Next contents: pop shifts slot 1 forward, push lands in the first free slot after that shift.
    always_comb begin
        pop_ok        = pop && (occ_reg != 2'd0);
        occ_after_pop = occ_reg - {1'b0, pop_ok};
        push_ok       = push && (occ_after_pop != 2'd2);
        occ_next      = occ_reg;
        slot_next[0]  = slot_reg[0];
        slot_next[1]  = slot_reg[1];
        if (clr) begin
            occ_next = 2'd0;
        end else begin
            if (pop_ok) begin
                slot_next[0] = slot_reg[1];
            end
            if (push_ok) begin
                slot_next[occ_after_pop[0]] = push_data;
            end
            occ_next = occ_after_pop + {1'b0, push_ok};
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg <= 2'd0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            // Data slot register; cleared on reset so dout reads 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg[gi] <= '0;
                end else begin
                    slot_reg[gi] <= slot_next[gi];
                end
            end
        end
    endgenerate

    assign head_data  = slot_reg[0];
    assign head_valid = (occ_reg != 2'd0);
    assign occ        = occ_reg;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a programmed byte count from the FIFO read port onto a valid/ready stream.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    fifo_drain_ctrl_if.master  bus
);

    state_t           state_reg;
    state_t           state_next;
    logic [LEN_W-1:0] rd_left_reg;
    logic [LEN_W-1:0] out_left_reg;
    logic             inflight_reg;
    logic             err_reg;
    logic             rd_en;
    logic             accept;
    logic             abort;
    logic             pop;
    logic             buf_valid;
    logic [1:0]       occ;
    logic [2:0]       pending;

    assign accept  = (state_reg == IDLE) && start;
    assign abort   = (state_reg == READ) && bus.under_flow;
    assign pop     = buf_valid && bus.dout_ready;
    // Bytes that will still be held after this cycle's pop, counting the one in flight.
    assign pending = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; underflow wins over normal completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (bus.under_flow) begin
                    state_next = DONE;
                end else if (pop && (out_left_reg == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; reads only while room remains for the returning byte.
    always_comb begin
        busy  = (state_reg != IDLE);
        done  = (state_reg == DONE);
        rd_en = (state_reg == READ) && !bus.under_flow && !bus.empty_sig &&
                (rd_left_reg != '0) && (pending < 3'd2);
    end

    // Remaining-read and remaining-delivery counters, both loaded on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_left_reg  <= '0;
            out_left_reg <= '0;
        end else if (accept) begin
            rd_left_reg  <= len;
            out_left_reg <= len;
        end else begin
            if (rd_en) begin
                rd_left_reg <= rd_left_reg - LEN_W'(1);
            end
            if (pop && (state_reg == READ) && (out_left_reg != '0)) begin
                out_left_reg <= out_left_reg - LEN_W'(1);
            end
        end
    end

    // Tracks the read whose data arrives on din next cycle; sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
            if (accept) begin
                err_reg <= 1'b0;
            end else if (abort) begin
                err_reg <= 1'b1;
            end
        end
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .push       (inflight_reg && !abort),
        .push_data  (bus.din),
        .pop        (pop),
        .head_data  (bus.dout),
        .head_valid (buf_valid),
        .occ        (occ)
    );

    assign bus.rd_sig     = rd_en;
    assign bus.dout_valid = buf_valid;
    assign err            = err_reg;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed plus randomized bench for fifo_drain_ctrl with a transaction-level reference model.
module tb_fifo_drain_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    fifo_drain_ctrl_if #(.DATA_W(8)) bus ();

    fifo_drain_ctrl #(.DATA_W(8), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: bytes sitting in the FIFO, all bytes pushed this burst, burst progress.
    logic [7:0] fq[$];
    logic [7:0] src[$];
    logic       in_burst  = 1'b0;
    logic       done_due  = 1'b0;
    logic       exp_err   = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    int         blen = 0, got = 0, issued = 0;
    int         cyc = 0, s_cyc = 0, pat_n = 0;
    int         ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 manual
    logic       glitch = 1'b0;
    int         first_rd, last_rd, first_hs, last_hs, done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic fpush(input logic [7:0] b);
        fq.push_back(b);
        src.push_back(b);
    endtask

    task automatic clear_marks();
        first_rd = -1; last_rd = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    endtask

    // One clock cycle: drive ready/empty, check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic       rd, dv, hs, uf, rdy, ex_done, accepted;
        logic [7:0] d;
        case (ready_mode)
            0: bus.dout_ready = 1'b1;
            1: bus.dout_ready = (pat_n % 3 == 0);
            2: bus.dout_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
        pat_n++;
        bus.empty_sig = (fq.size() == 0);
        #1;
        rd  = bus.rd_sig;
        dv  = bus.dout_valid;
        d   = bus.dout;
        rdy = bus.dout_ready;
        uf  = bus.under_flow;
        hs  = dv && rdy;
        ex_done  = done_due;
        done_due = 1'b0;
        chk("done", 32'(done), 32'(ex_done));
        chk("busy", 32'(busy), 32'(in_burst || ex_done));
        chk("err", 32'(err), 32'(exp_err));
        if (!in_burst) begin
            chk("rd_idle", 32'(rd), 32'd0);
            chk("dv_idle", 32'(dv), 32'd0);
        end
        if (rd) begin
            chk("rd_when_empty", 32'(bus.empty_sig), 32'd0);
            chk("rd_beyond_len", 32'(issued < blen), 32'd1);
        end
        if (in_burst && uf) chk("rd_on_underflow", 32'(rd), 32'd0);
        if (prev_stall) begin
            chk("hold_valid", 32'(dv), 32'd1);
            chk("hold_data", 32'(d), 32'(prev_dout));
        end
        if (hs && in_burst) begin
            chk("byte_count", 32'(got < blen), 32'd1);
            if (got < src.size()) chk("data", 32'(d), 32'(src[got]));
            $display("cycle %0d: byte %0d = %02h", cyc, got, d);
        end
        if (rd && first_rd < 0) first_rd = cyc;
        if (rd) last_rd = cyc;
        if (hs && first_hs < 0) first_hs = cyc;
        if (hs) last_hs = cyc;
        if (done) done_cyc = cyc;
        accepted = start && !(in_burst || ex_done);
        @(posedge clk);
        #1;
        if (rd) begin
            issued++;
            bus.din = (fq.size() != 0) ? fq.pop_front() : 8'($urandom);
        end else begin
            bus.din = 8'($urandom);
        end
        if (hs) got++;
        prev_stall = dv && !rdy;
        prev_dout  = d;
        if (in_burst && uf) begin
            in_burst = 1'b0; done_due = 1'b1; exp_err = 1'b1; prev_stall = 1'b0;
        end else if (in_burst && hs && got == blen) begin
            in_burst = 1'b0; done_due = 1'b1;
            chk("read_total", 32'(issued), 32'(blen));
        end
        if (in_burst) chk("occ_bound", 32'((issued - got) <= 2), 32'd1);
        if (accepted) begin
            exp_err = 1'b0; blen = int'(len); got = 0; issued = 0; s_cyc = cyc;
            if (len == 16'd0) done_due = 1'b1;
            else              in_burst = 1'b1;
            $display("cycle %0d: start accepted len=%0d", cyc, len);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to_idle(input int max_cyc);
        int n;
        n = 0;
        while ((in_burst || done_due) && n < max_cyc) begin
            if (glitch) begin
                start = ($urandom_range(0, 7) == 0);
                len   = 16'($urandom_range(0, 20));
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("timeout", 32'(in_burst || done_due), 32'd0);
    endtask

    task automatic begin_burst(input int l);
        start = 1'b1;
        len   = 16'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rd"}, 32'(bus.rd_sig), 32'd0);
        chk({tag, "_dv"}, 32'(bus.dout_valid), 32'd0);
        chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 16'd0;
        bus.empty_sig = 1'b1; bus.under_flow = 1'b0; bus.din = 8'h00; bus.dout_ready = 1'b1;
        clear_marks();
        @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic 4-byte burst, consumer always ready.
        ready_mode = 0; fq.delete(); src.delete(); clear_marks();
        for (int i = 0; i < 4; i++) fpush(8'(8'h11 + i));
        begin_burst(4);
        run_to_idle(50);
        chk("t1_first_rd", 32'(first_rd), 32'(s_cyc + 1));
        chk("t1_last_rd", 32'(last_rd), 32'(s_cyc + 4));
        chk("t1_first_byte", 32'(first_hs), 32'(s_cyc + 3));
        chk("t1_last_byte", 32'(last_hs), 32'(s_cyc + 6));
        chk("t1_done", 32'(done_cyc), 32'(s_cyc + 7));
        chk("t1_got", 32'(got), 32'd4);
        tick();

        // Stalling consumer.
        ready_mode = 1; fq.delete(); src.delete();
        for (int i = 0; i < 6; i++) fpush(8'($urandom));
        begin_burst(6);
        run_to_idle(100);
        chk("t2_got", 32'(got), 32'd6);
        ready_mode = 0; tick();

        // FIFO runs dry mid-burst, refilled later.
        fq.delete(); src.delete();
        fpush(8'hA1); fpush(8'hA2);
        begin_burst(5);
        repeat (10) tick();
        chk("t3_partial", 32'(got), 32'd2);
        fpush(8'hA3); fpush(8'hA4); fpush(8'hA5);
        run_to_idle(50);
        chk("t3_got", 32'(got), 32'd5);
        tick();

        // Zero-length request.
        fq.delete(); src.delete(); fpush(8'h55); clear_marks();
        begin_burst(0);
        run_to_idle(10);
        chk("t4_done", 32'(done_cyc), 32'(s_cyc + 1));
        chk("t4_no_rd", 32'(first_rd), 32'hFFFF_FFFF);
        tick();

        // Underflow with two bytes buffered.
        ready_mode = 3; bus.dout_ready = 1'b0; fq.delete(); src.delete();
        for (int i = 0; i < 6; i++) fpush(8'($urandom));
        begin_burst(6);
        repeat (4) tick();
        chk("t5_buffered", 32'(issued - got), 32'd2);
        chk("t5_valid", 32'(bus.dout_valid), 32'd1);
        bus.under_flow = 1'b1;
        tick();
        bus.under_flow = 1'b0;
        repeat (3) tick();
        bus.under_flow = 1'b1;          // ignored outside a burst
        tick();
        bus.under_flow = 1'b0;
        tick();
        ready_mode = 0; fq.delete(); src.delete();
        fpush(8'h3C);
        begin_burst(1);
        run_to_idle(20);
        chk("t5_err_cleared", 32'(err), 32'd0);

        // Asynchronous reset mid-burst with a full buffer.
        ready_mode = 3; bus.dout_ready = 1'b0; fq.delete(); src.delete();
        for (int i = 0; i < 6; i++) fpush(8'($urandom));
        begin_burst(6);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        in_burst = 1'b0; done_due = 1'b0; exp_err = 1'b0; prev_stall = 1'b0;
        fq.delete(); src.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        tick();
        for (int i = 0; i < 3; i++) fpush(8'(8'hC0 + i));
        begin_burst(3);
        run_to_idle(30);
        chk("t6_got", 32'(got), 32'd3);
        chk("t6_reads", 32'(issued), 32'd3);
        tick();

        // Randomized bursts: lengths, consumer behaviour, late data, start while busy.
        for (int t = 0; t < 24; t++) begin
            int l, split;
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            ready_mode = int'($urandom_range(0, 2));
            glitch = 1'($urandom_range(0, 1));
            fq.delete(); src.delete();
            split = ($urandom_range(0, 1) != 0) ? l : int'($urandom_range(0, l));
            for (int i = 0; i < split; i++) fpush(8'($urandom));
            begin_burst(l);
            if (split < l) begin
                repeat (5) tick();
                for (int i = split; i < l; i++) fpush(8'($urandom));
            end
            run_to_idle(300);
            glitch = 1'b0;
            chk("rand_got", 32'(got), 32'(l));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound in case the sequence itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
